// File: rtl/ibex_float2int.sv
// Multi-cycle binary32 -> 32-bit integer converter for FCVT.W.S / FCVT.WU.S.
// Honours RISC-V rounding modes and produces RISC-V saturation values plus NV/NX flags.
`timescale 1ns/1ps
module ibex_float2int (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] input_a_i,
    input  logic [2:0]  rm_i,
    input  logic        is_signed_i,
    input  logic        convert_en_i,
    output logic        ready_o,
    output logic [31:0] output_z_o,
    output logic        invalid_o,
    output logic        inexact_o,
    output logic        convert_valid_o
);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ROUND, SAT, DONE} state_t;

    state_t state_q, state_d;

    logic [31:0]       a_q;
    logic [2:0]        rm_q;
    logic              signed_q;
    logic              nan_q;
    logic              special_q;
    logic signed [9:0] e_q;
    logic [23:0]       m_q;
    logic [32:0]       mag_q;
    logic              g_q;
    logic              st_q;
    logic              ovf_q;

    logic [7:0]  exp_w;
    logic [22:0] frac_w;
    logic [62:0] shifted;
    logic [32:0] align_mag;
    logic        align_g;
    logic        align_s;
    logic        align_ovf;
    logic        inc;
    logic        neg;
    logic        in_range;
    logic [31:0] sat_z;
    logic        sat_nv;
    logic        sat_nx;

    assign exp_w   = a_q[30:23];
    assign frac_w  = a_q[22:0];
    assign ready_o = (state_q == IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (convert_en_i) state_d = UNPACK;
            UNPACK:  state_d = ALIGN;
            ALIGN:   state_d = ROUND;
            ROUND:   state_d = SAT;
            SAT:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Leading 1 sits at bit 31 before shifting, so the integer part lands in [62:31].
    always_comb begin
        shifted   = {31'b0, m_q, 8'b0} << e_q[4:0];
        align_mag = 33'b0;
        align_g   = 1'b0;
        align_s   = 1'b0;
        align_ovf = 1'b0;
        if (special_q || (!e_q[9] && (e_q[8:5] != 4'b0))) begin
            align_ovf = 1'b1;
        end else if (e_q[9]) begin
            align_g = (e_q == -10'sd1);
            align_s = (e_q == -10'sd1) ? (|m_q[22:0]) : (|m_q);
        end else begin
            align_mag = {1'b0, shifted[62:31]};
            align_g   = shifted[30];
            align_s   = |shifted[29:0];
        end
    end

    always_comb begin
        case (rm_q)
            3'b000:  inc = g_q & (st_q | mag_q[0]);
            3'b010:  inc = a_q[31] & (g_q | st_q);
            3'b011:  inc = ~a_q[31] & (g_q | st_q);
            3'b100:  inc = g_q;
            default: inc = 1'b0;
        endcase
    end

    // NaN saturates as a positive value regardless of its sign bit.
    always_comb begin
        neg = a_q[31] & ~nan_q;
        if (ovf_q)         in_range = 1'b0;
        else if (signed_q) in_range = neg ? (mag_q <= 33'h0_8000_0000) : (mag_q <= 33'h0_7FFF_FFFF);
        else               in_range = neg ? (mag_q == 33'b0) : ~mag_q[32];

        if (in_range) begin
            sat_z  = a_q[31] ? (~mag_q[31:0] + 32'd1) : mag_q[31:0];
            sat_nv = 1'b0;
            sat_nx = g_q | st_q;
        end else begin
            if (signed_q) sat_z = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else          sat_z = neg ? 32'h0000_0000 : 32'hFFFF_FFFF;
            sat_nv = 1'b1;
            sat_nx = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_q             <= 32'b0;
            rm_q            <= 3'b0;
            signed_q        <= 1'b0;
            nan_q           <= 1'b0;
            special_q       <= 1'b0;
            e_q             <= 10'sd0;
            m_q             <= 24'b0;
            mag_q           <= 33'b0;
            g_q             <= 1'b0;
            st_q            <= 1'b0;
            ovf_q           <= 1'b0;
            output_z_o      <= 32'b0;
            invalid_o       <= 1'b0;
            inexact_o       <= 1'b0;
            convert_valid_o <= 1'b0;
        end else begin
            convert_valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (convert_en_i) begin
                        a_q      <= input_a_i;
                        rm_q     <= rm_i;
                        signed_q <= is_signed_i;
                    end
                end
                UNPACK: begin
                    nan_q     <= (exp_w == 8'hFF) && (frac_w != 23'b0);
                    special_q <= (exp_w == 8'hFF);
                    e_q       <= $signed({2'b00, exp_w}) - 10'sd127;
                    m_q       <= {(exp_w != 8'h00), frac_w};
                end
                ALIGN: begin
                    mag_q <= align_mag;
                    g_q   <= align_g;
                    st_q  <= align_s;
                    ovf_q <= align_ovf;
                end
                ROUND: mag_q <= mag_q + {32'b0, inc};
                SAT: begin
                    output_z_o      <= sat_z;
                    invalid_o       <= sat_nv;
                    inexact_o       <= sat_nx;
                    convert_valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_float2int.sv
// Directed scoreboard bench for ibex_float2int: rounding modes, saturation,
// special values, handshake timing and mid-conversion reset.
`timescale 1ns/1ps
module tb_ibex_float2int;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] input_a_i = 32'b0;
    logic [2:0]  rm_i = 3'b0;
    logic        is_signed_i = 1'b0;
    logic        convert_en_i = 1'b0;
    logic        ready_o;
    logic [31:0] output_z_o;
    logic        invalid_o;
    logic        inexact_o;
    logic        convert_valid_o;

    typedef struct {
        logic [31:0] z;
        logic        nv;
        logic        nx;
        string       tag;
    } exp_t;

    exp_t sbQ[$];
    int   nPass  = 0;
    int   nFail  = 0;
    int   nTotal = 0;

    ibex_float2int dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .input_a_i      (input_a_i),
        .rm_i           (rm_i),
        .is_signed_i    (is_signed_i),
        .convert_en_i   (convert_en_i),
        .ready_o        (ready_o),
        .output_z_o     (output_z_o),
        .invalid_o      (invalid_o),
        .inexact_o      (inexact_o),
        .convert_valid_o(convert_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nTotal++;
        assert (obs === expv) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Waits for IDLE, issues one request and leaves the bench at the negedge after edge E.
    task automatic applyStimulus(input logic [31:0] a, input logic [2:0] rm, input logic sgn,
                                 input logic [31:0] z, input logic nv, input logic nx, input string tag);
        exp_t e;
        int   waitCnt = 0;
        @(negedge clk_i);
        while (!ready_o && waitCnt < 20) begin
            @(negedge clk_i);
            waitCnt++;
        end
        checkEq({tag, "/ready"}, {31'b0, ready_o}, 32'd1);
        input_a_i    = a;
        rm_i         = rm;
        is_signed_i  = sgn;
        convert_en_i = 1'b1;
        e.z = z; e.nv = nv; e.nx = nx; e.tag = tag;
        sbQ.push_back(e);
        @(negedge clk_i);
        convert_en_i = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t e;
        int   lat = 1;
        while (!convert_valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        if (sbQ.size() == 0) begin
            checkEq("scoreboard/empty", 32'd0, 32'd1);
            return;
        end
        e = sbQ.pop_front();
        checkEq({e.tag, "/latency"}, lat, 32'd5);
        checkEq({e.tag, "/z"}, output_z_o, e.z);
        checkEq({e.tag, "/nv"}, {31'b0, invalid_o}, {31'b0, e.nv});
        checkEq({e.tag, "/nx"}, {31'b0, inexact_o}, {31'b0, e.nx});
        @(negedge clk_i);
        checkEq({e.tag, "/pulse_end"}, {31'b0, convert_valid_o}, 32'd0);
    endtask

    task automatic runVector(input logic [31:0] a, input logic [2:0] rm, input logic sgn,
                             input logic [31:0] z, input logic nv, input logic nx, input string tag);
        applyStimulus(a, rm, sgn, z, nv, nx, tag);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   validCnt;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        checkEq("reset/ready", {31'b0, ready_o}, 32'd1);
        checkEq("reset/z", output_z_o, 32'd0);
        checkEq("reset/nv", {31'b0, invalid_o}, 32'd0);
        checkEq("reset/nx", {31'b0, inexact_o}, 32'd0);
        checkEq("reset/valid", {31'b0, convert_valid_o}, 32'd0);

        runVector(32'h40490FDB, 3'b000, 1'b1, 32'h00000003, 1'b0, 1'b1, "pi_rne");
        runVector(32'hBFC00000, 3'b000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, "m1p5_rne");
        runVector(32'hBFC00000, 3'b001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, "m1p5_rtz");
        runVector(32'hBFC00000, 3'b010, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, "m1p5_rdn");
        runVector(32'hBFC00000, 3'b011, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, "m1p5_rup");
        runVector(32'hBFC00000, 3'b100, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, "m1p5_rmm");
        runVector(32'hBFC00000, 3'b111, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, "m1p5_rm7");
        runVector(32'h40200000, 3'b000, 1'b1, 32'h00000002, 1'b0, 1'b1, "2p5_rne");
        runVector(32'h40200000, 3'b100, 1'b1, 32'h00000003, 1'b0, 1'b1, "2p5_rmm");
        runVector(32'h40200000, 3'b011, 1'b1, 32'h00000003, 1'b0, 1'b1, "2p5_rup");
        runVector(32'h40600000, 3'b000, 1'b1, 32'h00000004, 1'b0, 1'b1, "3p5_rne");
        runVector(32'h80000000, 3'b000, 1'b1, 32'h00000000, 1'b0, 1'b0, "neg_zero");
        runVector(32'h3F000000, 3'b100, 1'b0, 32'h00000001, 1'b0, 1'b1, "half_rmm");
        runVector(32'h3E800000, 3'b011, 1'b1, 32'h00000001, 1'b0, 1'b1, "quarter_rup");
        runVector(32'h00000001, 3'b011, 1'b1, 32'h00000001, 1'b0, 1'b1, "subnorm_rup");
        runVector(32'h4F000000, 3'b000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, "p2e31_s");
        runVector(32'hCF000000, 3'b000, 1'b1, 32'h80000000, 1'b0, 1'b0, "m2e31_s");
        runVector(32'h4F000000, 3'b000, 1'b0, 32'h80000000, 1'b0, 1'b0, "p2e31_u");
        runVector(32'h4F800000, 3'b000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, "p2e32_u");
        runVector(32'h4F7FFFFF, 3'b000, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0, "max_u");
        runVector(32'h7FC00000, 3'b000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, "nan_s");
        runVector(32'hFFC00000, 3'b000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, "negnan_u");
        runVector(32'hFF800000, 3'b000, 1'b0, 32'h00000000, 1'b1, 1'b0, "minf_u");
        runVector(32'hFF800000, 3'b000, 1'b1, 32'h80000000, 1'b1, 1'b0, "minf_s");
        runVector(32'hBF000000, 3'b001, 1'b0, 32'h00000000, 1'b0, 1'b1, "mhalf_u_rtz");
        runVector(32'hBF000000, 3'b010, 1'b0, 32'h00000000, 1'b1, 1'b0, "mhalf_u_rdn");

        // Request held high: one result per acceptance, ready low for five cycles each time.
        @(negedge clk_i);
        input_a_i    = 32'h41200000;
        rm_i         = 3'b000;
        is_signed_i  = 1'b1;
        convert_en_i = 1'b1;
        for (int n = 0; n < 2; n++) begin
            e.z = 32'd10; e.nv = 1'b0; e.nx = 1'b0; e.tag = "held";
            sbQ.push_back(e);
        end
        validCnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_i);
            checkEq($sformatf("held/ready_k%0d", k), {31'b0, ready_o}, {31'b0, (k % 6) == 0});
            checkEq($sformatf("held/valid_k%0d", k), {31'b0, convert_valid_o}, {31'b0, (k % 6) == 5});
            if (convert_valid_o && sbQ.size() > 0) begin
                e = sbQ.pop_front();
                validCnt++;
                checkEq("held/z", output_z_o, e.z);
                checkEq("held/flags", {30'b0, invalid_o, inexact_o}, {30'b0, e.nv, e.nx});
            end
        end
        convert_en_i = 1'b0;
        checkEq("held/results", validCnt, 32'd2);

        // Reset at E+2 aborts the conversion with no valid pulse.
        applyStimulus(32'h40490FDB, 3'b000, 1'b1, 32'h00000003, 1'b0, 1'b1, "abort");
        void'(sbQ.pop_back());
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        checkEq("abort/ready", {31'b0, ready_o}, 32'd1);
        checkEq("abort/z", output_z_o, 32'd0);
        checkEq("abort/flags", {30'b0, invalid_o, inexact_o}, 32'd0);
        validCnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (convert_valid_o) validCnt++;
            @(negedge clk_i);
        end
        checkEq("abort/no_pulse", validCnt, 32'd0);

        runVector(32'hC2F6E979, 3'b001, 1'b1, 32'hFFFFFF85, 1'b0, 1'b1, "after_abort");

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
